// File: rtl/rx_bit_sampler.sv
// rx_bit_sampler: oversampled bit timing with three-sample majority vote for the UART receiver
module rx_bit_sampler #(
    parameter int PRESCALE_W = 6,
    parameter int BIT_CNT_W  = 4
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  En,
    input  logic                  RX_IN,
    input  logic [PRESCALE_W-1:0] Prescale,
    output logic [PRESCALE_W-1:0] Edge_Cnt,
    output logic [BIT_CNT_W-1:0]  Bit_Cnt,
    output logic                  Sampled_Bit,
    output logic                  Sample_Valid
);
    logic [PRESCALE_W-1:0] p, p_in, p_last, mid, mid_lo, mid_hi;
    logic                  s0, s1, maj;
    // Prescale is only captured between frames, so mid-frame changes are ignored
    assign p_in   = (Prescale < PRESCALE_W'(4)) ? PRESCALE_W'(4) : Prescale;
    assign p_last = p - PRESCALE_W'(1);
    assign mid    = p >> 1;
    assign mid_lo = mid - PRESCALE_W'(1);
    assign mid_hi = mid + PRESCALE_W'(1);
    assign maj    = (s0 & s1) | (s0 & RX_IN) | (s1 & RX_IN);
    always_ff @(posedge CLK or negedge RST)
        if (!RST) begin
            p            <= PRESCALE_W'(8);
            Edge_Cnt     <= '0;
            Bit_Cnt      <= '0;
            Sampled_Bit  <= 1'b1;
            Sample_Valid <= 1'b0;
            s0           <= 1'b1;
            s1           <= 1'b1;
        end else if (!En) begin
            p            <= p_in;
            Edge_Cnt     <= '0;
            Bit_Cnt      <= '0;
            Sample_Valid <= 1'b0;
        end else begin
            Edge_Cnt     <= (Edge_Cnt == p_last) ? '0 : Edge_Cnt + PRESCALE_W'(1);
            if (Edge_Cnt == p_last) Bit_Cnt <= Bit_Cnt + BIT_CNT_W'(1);
            if (Edge_Cnt == mid_lo) s0 <= RX_IN;
            if (Edge_Cnt == mid) s1 <= RX_IN;
            if (Edge_Cnt == mid_hi) Sampled_Bit <= maj;
            Sample_Valid <= (Edge_Cnt == mid_hi);
        end
endmodule

// File: tb/tb_rx_bit_sampler.sv
// tb_rx_bit_sampler: directed and randomized checks of rx_bit_sampler against a frame-cycle reference model
module tb_rx_bit_sampler;
    logic       CLK = 1'b0;
    logic       RST, En, RX_IN;
    logic [5:0] Prescale;
    logic [5:0] Edge_Cnt;
    logic [3:0] Bit_Cnt;
    logic       Sampled_Bit, Sample_Valid;

    int n_cmp = 0, n_bad = 0;
    // model: fk = cycle index within the current frame (0 when idle), pf = frame ratio
    int fk = 0, pf = 8, platch = 8, last_sb = 1;
    int rxh[4096];
    int sv_at[$];
    int sb_q[$];
    int max_bit = 0;
    int bits[10] = '{0, 1, 0, 1, 1, 0, 0, 1, 0, 1};
    int legal[4] = '{2, 8, 16, 32};

    always #5 CLK = ~CLK;

    rx_bit_sampler dut (
        .CLK(CLK), .RST(RST), .En(En), .RX_IN(RX_IN), .Prescale(Prescale),
        .Edge_Cnt(Edge_Cnt), .Bit_Cnt(Bit_Cnt), .Sampled_Bit(Sampled_Bit), .Sample_Valid(Sample_Valid)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int maj3(input int a, input int b, input int c);
        return (a + b + c >= 2) ? 1 : 0;
    endfunction

    function automatic int at(input int q[$], input int i);
        return (i < q.size()) ? q[i] : -1;
    endfunction

    task automatic check_now();
        int mid = pf / 2;
        int sv;
        sv = (fk >= mid + 2 && (fk - mid - 2) % pf == 0) ? 1 : 0;
        if (sv == 1) last_sb = maj3(rxh[fk-3], rxh[fk-2], rxh[fk-1]);
        chk("edge_cnt", Edge_Cnt, fk % pf);
        chk("bit_cnt", Bit_Cnt, (fk / pf) % 16);
        chk("sample_valid", Sample_Valid, sv);
        chk("sampled_bit", Sampled_Bit, last_sb);
        if (Sample_Valid) begin
            sv_at.push_back(fk);
            sb_q.push_back(int'(Sampled_Bit));
        end
        if (int'(Bit_Cnt) > max_bit) max_bit = int'(Bit_Cnt);
    endtask

    task automatic cyc(input logic en, input logic rx, input int ps);
        En = en;
        RX_IN = rx;
        Prescale = 6'(ps);
        check_now();
        if (!RST) begin
            fk = 0; platch = 8; last_sb = 1;
        end else if (en) begin
            if (fk == 0) pf = platch;
            rxh[fk] = int'(rx);
            fk++;
        end else begin
            fk = 0;
            platch = (ps < 4) ? 4 : ps;
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic clear_obs();
        sv_at.delete();
        sb_q.delete();
        max_bit = 0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int ps, len;
        RST = 1'b1; En = 1'b0; RX_IN = 1'b1; Prescale = 6'd8;
        #1 RST = 1'b0;
        #1;
        // reset held with random inputs, then released with En low
        repeat (4) cyc(1'($urandom % 2), 1'($urandom % 2), int'($urandom_range(0, 40)));
        En = 1'b0;
        RST = 1'b1;
        repeat (3) cyc(1'b0, 1'($urandom % 2), 8);

        // P=8 ten-bit frame
        cyc(1'b0, 1'b1, 8);
        clear_obs();
        for (int c = 0; c < 80; c++) cyc(1'b1, 1'(bits[c/8]), 8);
        chk("p8_strobes", sv_at.size(), 10);
        chk("p8_bitcnt_max", max_bit, 9);
        for (int i = 0; i < 10; i++) begin
            chk("p8_strobe_cycle", at(sv_at, i), 6 + 8 * i);
            chk("p8_bit", at(sb_q, i), bits[i]);
        end
        cyc(1'b0, 1'b1, 8);

        // P=16 single glitch voted out, double glitch wins
        cyc(1'b0, 1'b1, 16);
        clear_obs();
        for (int c = 0; c < 16; c++) cyc(1'b1, (c == 7) ? 1'b0 : 1'b1, 16);
        chk("glitch1_strobes", sv_at.size(), 1);
        chk("glitch1_bit", at(sb_q, 0), 1);
        cyc(1'b0, 1'b1, 16);
        clear_obs();
        for (int c = 0; c < 16; c++) cyc(1'b1, (c == 7 || c == 8) ? 1'b0 : 1'b1, 16);
        chk("glitch2_bit", at(sb_q, 0), 0);
        cyc(1'b0, 1'b1, 16);

        // Prescale change mid-frame takes effect only next frame
        cyc(1'b0, 1'b1, 8);
        clear_obs();
        for (int c = 0; c < 40; c++) cyc(1'b1, 1'($urandom % 2), (c < 3) ? 8 : 32);
        chk("hold_strobes", sv_at.size(), 5);
        for (int i = 0; i < 5; i++) chk("hold_strobe_cycle", at(sv_at, i), 6 + 8 * i);
        cyc(1'b0, 1'b1, 32);
        clear_obs();
        for (int c = 0; c < 40; c++) cyc(1'b1, 1'($urandom % 2), 32);
        chk("p32_strobes", sv_at.size(), 1);
        chk("p32_first_strobe", at(sv_at, 0), 18);
        cyc(1'b0, 1'b1, 32);

        // En dropped at cycle 5, raised again next cycle
        cyc(1'b0, 1'b1, 8);
        clear_obs();
        for (int c = 0; c < 5; c++) cyc(1'b1, 1'($urandom % 2), 8);
        cyc(1'b0, 1'($urandom % 2), 8);
        chk("drop_no_strobe", sv_at.size(), 0);
        clear_obs();
        for (int c = 0; c < 10; c++) cyc(1'b1, 1'($urandom % 2), 8);
        chk("restart_strobes", sv_at.size(), 1);
        chk("restart_first_strobe", at(sv_at, 0), 6);
        cyc(1'b0, 1'b1, 8);

        // asynchronous reset at cycle 13 of a P=8 frame
        cyc(1'b0, 1'b1, 8);
        for (int c = 0; c < 13; c++) cyc(1'b1, 1'b0, 8);
        RST = 1'b0;
        #1;
        chk("arst_edge", Edge_Cnt, 0);
        chk("arst_bit", Bit_Cnt, 0);
        chk("arst_sampled", Sampled_Bit, 1);
        chk("arst_valid", Sample_Valid, 0);
        fk = 0; platch = 8; last_sb = 1;
        clear_obs();
        repeat (2) cyc(1'b1, 1'b0, 8);
        chk("arst_no_strobe", sv_at.size(), 0);
        En = 1'b0;
        RST = 1'b1;
        repeat (2) cyc(1'b0, 1'b1, 8);

        // randomized frames, including sub-minimum prescale and mid-frame prescale noise
        repeat (10) begin
            ps = legal[$urandom % 4];
            repeat ($urandom_range(1, 3)) cyc(1'b0, 1'($urandom % 2), ps);
            len = int'($urandom_range(10, 120));
            for (int c = 0; c < len; c++)
                cyc(1'b1, 1'($urandom % 2), ($urandom % 8 == 0) ? legal[$urandom % 4] : ps);
        end
        cyc(1'b0, 1'b1, 8);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
